// File: rtl/speaker_arbiter.sv
// speaker_arbiter
//
// Shares the single play_sound tone generator between several sound sources
// (key-press tones, pass jingle, fail sweep, attract chirps). Each source asks
// for a tone with a frequency in Hz and a duration in ms ticks. The lowest
// requesting index wins. The winning tone is driven on `frequency` for exactly
// dur ms, followed by an optional silent gap of GAP_MS ms. The source is then
// told that its tone has finished.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   clk_counter  ms prescale; one tick every clk_counter+1 cycles
//   flush        abort the current tone/gap and return to idle
//   req          per-source request level (index 0 = highest priority)
//   req_freq     packed frequencies, source i at [10i+9:10i]
//   req_dur      packed durations in ticks, same packing
//   ack          one-cycle pulse when source i is accepted (combinational)
//   done         one-cycle pulse when source i's tone ends (combinational)
//   frequency    tone to play_sound, 0 = silence
//   busy         high while playing or in the silent gap
//   owner        index of the source currently playing, valid while busy
module speaker_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GAP_MS  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           clk_counter,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_freq,
  input  logic [NUM_REQ*10-1:0] req_dur,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    done,
  output logic [9:0]            frequency,
  output logic                  busy,
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cycCount_q, cycCount_d;
  logic [9:0]          remaining_q, remaining_d;
  logic [15:0]         gapCount_q, gapCount_d;
  logic [9:0]          freq_q, freq_d;
  logic [1:0]          owner_q, owner_d;

  logic                tick;
  logic                reqValid;
  logic [1:0]          reqIdx;
  logic [NUM_REQ-1:0]  reqOneHot;
  logic [NUM_REQ-1:0]  ownerOneHot;
  logic [9:0]          selFreq;
  logic [9:0]          selDur;

  // The ms tick fires on the last cycle of each prescale period.
  assign tick = (cycCount_q == clk_counter);

  // Fixed-priority pick. Scanning from the top index down lets the lowest
  // requesting index overwrite everything above it, so it ends up the winner.
  always_comb begin
    reqValid  = 1'b0;
    reqIdx    = 2'd0;
    reqOneHot = '0;
    selFreq   = 10'd0;
    selDur    = 10'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        reqValid     = 1'b1;
        reqIdx       = 2'(i);
        reqOneHot    = '0;
        reqOneHot[i] = 1'b1;
        selFreq      = req_freq[10*i +: 10];
        selDur       = req_dur[10*i +: 10];
      end
    end
  end

  // One-hot form of the current owner, used to steer the done pulse.
  always_comb begin
    ownerOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ownerOneHot[i] = (owner_q == 2'(i));
    end
  end

  // Next-state logic and pulse outputs. Reset silences the pulses right away.
  // Flush outranks everything else, so an aborted tone never reports done and
  // no source is accepted while flush is high. The prescaler is restarted on
  // every accept and on entry to the gap. That makes each phase an exact
  // multiple of clk_counter+1 cycles, whatever the free-running count was.
  always_comb begin
    state_d     = state_q;
    cycCount_d  = tick ? 16'd0 : cycCount_q + 16'd1;
    remaining_d = remaining_q;
    gapCount_d  = gapCount_q;
    freq_d      = freq_q;
    owner_d     = owner_q;
    ack         = '0;
    done        = '0;

    if (rst) begin
      state_d = ST_IDLE;
    end else if (flush) begin
      state_d    = ST_IDLE;
      freq_d     = 10'd0;
      cycCount_d = 16'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (reqValid) begin
            ack        = reqOneHot;
            cycCount_d = 16'd0;
            if (selDur == 10'd0) begin
              // A zero-length tone finishes as soon as it is accepted.
              done = reqOneHot;
            end else begin
              state_d     = ST_PLAY;
              freq_d      = selFreq;
              owner_d     = reqIdx;
              remaining_d = selDur;
            end
          end
        end

        ST_PLAY: begin
          if (tick) begin
            if (remaining_q == 10'd1) begin
              freq_d = 10'd0;
              done   = ownerOneHot;
              if (GAP_MS > 0) begin
                state_d    = ST_GAP;
                gapCount_d = 16'(GAP_MS);
                cycCount_d = 16'd0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              remaining_d = remaining_q - 10'd1;
            end
          end
        end

        ST_GAP: begin
          freq_d = 10'd0;
          if (tick) begin
            if (gapCount_q == 16'd1) begin
              state_d = ST_IDLE;
            end else begin
              gapCount_d = gapCount_q - 16'd1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          freq_d  = 10'd0;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycCount_q  <= 16'd0;
      remaining_q <= 10'd0;
      gapCount_q  <= 16'd0;
      freq_q      <= 10'd0;
      owner_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      cycCount_q  <= cycCount_d;
      remaining_q <= remaining_d;
      gapCount_q  <= gapCount_d;
      freq_q      <= freq_d;
      owner_q     <= owner_d;
    end
  end

  assign frequency = freq_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_speaker_arbiter.sv
// tb_speaker_arbiter
//
// Bench for speaker_arbiter. Expected outputs come from a timeline model. A
// tone accepted at offset 0 sounds on offsets 1..dur*P, where P is
// clk_counter+1. Its done pulse lands on offset dur*P. busy covers offsets
// 1..(dur+gap)*P. A second instance with no gap covers the back-to-back case.
module tb_speaker_arbiter;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clk_counter;
  logic        flush;

  logic [2:0]  req;
  logic [29:0] req_freq;
  logic [29:0] req_dur;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [9:0]  frequency;
  logic        busy;
  logic [1:0]  owner;

  logic [2:0]  reqB;
  logic [29:0] reqFreqB;
  logic [29:0] reqDurB;
  logic [2:0]  ackB;
  logic [2:0]  doneB;
  logic [9:0]  frequencyB;
  logic        busyB;
  logic [1:0]  ownerB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  speaker_arbiter #(.NUM_REQ(3), .GAP_MS(GAP)) dut (
    .clk(clk), .rst(rst), .clk_counter(clk_counter), .flush(flush),
    .req(req), .req_freq(req_freq), .req_dur(req_dur),
    .ack(ack), .done(done), .frequency(frequency), .busy(busy), .owner(owner)
  );

  speaker_arbiter #(.NUM_REQ(3), .GAP_MS(0)) dutNoGap (
    .clk(clk), .rst(rst), .clk_counter(clk_counter), .flush(flush),
    .req(reqB), .req_freq(reqFreqB), .req_dur(reqDurB),
    .ack(ackB), .done(doneB), .frequency(frequencyB), .busy(busyB), .owner(ownerB)
  );

  // Timeline model, offsets relative to the accept cycle
  function automatic logic [9:0] mFreq(int off, int f, int d, int p);
    if (d > 0 && off >= 1 && off <= d * p) return 10'(f);
    return 10'd0;
  endfunction

  function automatic logic mBusy(int off, int d, int p, int g);
    return (d > 0 && off >= 1 && off <= (d + g) * p);
  endfunction

  function automatic logic mDone(int off, int d, int p);
    return (off == d * p);
  endfunction

  task automatic set_field(int i, int f, int d);
    req_freq[10*i +: 10] = 10'(f);
    req_dur[10*i +: 10]  = 10'(d);
  endtask

  task automatic set_field_b(int i, int f, int d);
    reqFreqB[10*i +: 10] = 10'(f);
    reqDurB[10*i +: 10]  = 10'(d);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; clk_counter = 16'd3;
    req = 3'b111; reqB = 3'b111;
    for (int i = 0; i < 3; i++) begin
      set_field(i, 300, 5);
      set_field_b(i, 300, 5);
    end
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({ack, done, frequency, busy, owner} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_main got ack=%b done=%b freq=%0d busy=%b owner=%0d exp all 0", ack, done, frequency, busy, owner);
    end
    checks++;
    if ({ackB, doneB, frequencyB, busyB, ownerB} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_nogap got ack=%b done=%b freq=%0d busy=%b owner=%0d exp all 0", ackB, doneB, frequencyB, busyB, ownerB);
    end
    @(negedge clk);
    rst = 1'b0; req = 3'b000; reqB = 3'b000;
    #2;
    checks++;
    if ({ack, done, frequency, busy, owner} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_release got ack=%b done=%b freq=%0d busy=%b owner=%0d exp all 0", ack, done, frequency, busy, owner);
    end
  endtask

  task automatic test_single_tone();
    int p, last;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    clk_counter = 16'd3; p = 4;
    set_field(1, 262, 3);
    last = (3 + GAP) * p + 1;
    for (int off = 0; off <= last; off++) begin
      @(negedge clk);
      req = (off == 0) ? 3'b010 : 3'b000;
      #2;
      eAck  = (off == 0) ? 3'b010 : 3'b000;
      eDone = mDone(off, 3, p) ? 3'b010 : 3'b000;
      eFreq = mFreq(off, 262, 3, p);
      eBusy = mBusy(off, 3, p, GAP);
      checks++;
      if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL single_tone off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
      end
      if (eBusy) begin
        checks++;
        if (owner !== 2'd1) begin
          failures++;
          $display("[TB] FAIL single_owner off=%0d got %0d exp 1", off, owner);
        end
      end
    end
  endtask

  task automatic test_priority();
    int p, startB, last;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy, busyA, busyB2;
    clk_counter = 16'd3; p = 4;
    set_field(0, 196, 2);
    set_field(2, 784, 2);
    startB = (2 + GAP) * p + 1;
    last   = startB + (2 + GAP) * p + 1;
    for (int off = 0; off <= last; off++) begin
      @(negedge clk);
      req[0] = (off == 0) || (off >= startB + 2 && off <= startB + 5);
      req[1] = 1'b0;
      req[2] = (off <= startB);
      #2;
      busyA  = mBusy(off, 2, p, GAP);
      busyB2 = mBusy(off - startB, 2, p, GAP);
      eAck   = ((off == 0) ? 3'b001 : 3'b000) | ((off == startB) ? 3'b100 : 3'b000);
      eDone  = (mDone(off, 2, p) ? 3'b001 : 3'b000) | (mDone(off - startB, 2, p) ? 3'b100 : 3'b000);
      eFreq  = mFreq(off, 196, 2, p) | mFreq(off - startB, 784, 2, p);
      eBusy  = busyA | busyB2;
      checks++;
      if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL priority off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
      end
      if (eBusy) begin
        checks++;
        if (owner !== (busyA ? 2'd0 : 2'd2)) begin
          failures++;
          $display("[TB] FAIL priority_owner off=%0d got %0d exp %0d", off, owner, busyA ? 0 : 2);
        end
      end
    end
  endtask

  task automatic test_zero_dur();
    int p, last;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    clk_counter = 16'd3; p = 4;
    set_field(2, 500, 0);
    set_field(1, 440, 1);
    last = 1 + (1 + GAP) * p + 1;
    for (int off = 0; off <= last; off++) begin
      @(negedge clk);
      req = (off == 0) ? 3'b100 : (off == 1) ? 3'b010 : 3'b000;
      #2;
      eAck  = (off == 0) ? 3'b100 : (off == 1) ? 3'b010 : 3'b000;
      eDone = ((off == 0) ? 3'b100 : 3'b000) | (mDone(off - 1, 1, p) ? 3'b010 : 3'b000);
      eFreq = mFreq(off - 1, 440, 1, p);
      eBusy = mBusy(off - 1, 1, p, GAP);
      checks++;
      if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL zero_dur off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
      end
    end
  endtask

  task automatic test_flush();
    int p, startB, last;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    clk_counter = 16'd3; p = 4;
    set_field(0, 330, 10);
    set_field(1, 555, 1);
    startB = 17;
    last   = startB + (1 + GAP) * p + 1;
    for (int off = 0; off <= last; off++) begin
      @(negedge clk);
      req   = (off == 0) ? 3'b001 : (off == 16 || off == 17) ? 3'b010 : 3'b000;
      flush = (off == 16);
      #2;
      eAck  = (off == 0) ? 3'b001 : (off == startB) ? 3'b010 : 3'b000;
      eDone = mDone(off - startB, 1, p) ? 3'b010 : 3'b000;
      eFreq = ((off >= 1 && off <= 16) ? 10'd330 : 10'd0) | mFreq(off - startB, 555, 1, p);
      eBusy = (off >= 1 && off <= 16) | mBusy(off - startB, 1, p, GAP);
      checks++;
      if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL flush off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_withdrawn();
    int p;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    clk_counter = 16'd3; p = 4;
    set_field(0, 100, 2);
    set_field(1, 600, 3);
    set_field(2, 77, 0);
    for (int off = 0; off <= 20; off++) begin
      @(negedge clk);
      req   = (off == 0) ? 3'b001 : (off == 3) ? 3'b010 : (off == 18 || off == 19) ? 3'b100 : 3'b000;
      flush = (off == 18);
      #2;
      eAck  = (off == 0) ? 3'b001 : (off == 19) ? 3'b100 : 3'b000;
      eDone = (mDone(off, 2, p) ? 3'b001 : 3'b000) | ((off == 19) ? 3'b100 : 3'b000);
      eFreq = mFreq(off, 100, 2, p);
      eBusy = mBusy(off, 2, p, GAP);
      checks++;
      if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL withdrawn off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_gap();
    int p;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    clk_counter = 16'd3; p = 4;
    set_field(1, 262, 1);
    set_field(0, 123, 3);
    for (int off = 0; off <= 9; off++) begin
      @(negedge clk);
      rst = (off == 7);
      req = (off == 0) ? 3'b010 : (off == 7) ? 3'b001 : 3'b000;
      #2;
      eAck  = (off == 0) ? 3'b010 : 3'b000;
      eDone = mDone(off, 1, p) ? 3'b010 : 3'b000;
      eFreq = mFreq(off, 262, 1, p);
      eBusy = (off <= 7) && mBusy(off, 1, p, GAP);
      checks++;
      if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL reset_gap off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
      end
      if (off >= 8 || eBusy) begin
        checks++;
        if (owner !== ((off >= 8) ? 2'd0 : 2'd1)) begin
          failures++;
          $display("[TB] FAIL reset_gap_owner off=%0d got %0d exp %0d", off, owner, (off >= 8) ? 0 : 1);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p, startB, last;
    logic [2:0] eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    clk_counter = 16'd1; p = 2;
    set_field_b(2, 700, 2);
    startB = 2 * p + 1;
    last   = startB + 1 * p + 2;
    for (int off = 0; off <= last; off++) begin
      @(negedge clk);
      if (off == 4) set_field_b(2, 800, 1);
      reqB = (off == 0 || off == 4 || off == 5) ? 3'b100 : 3'b000;
      #2;
      eAck  = (off == 0 || off == startB) ? 3'b100 : 3'b000;
      eDone = (mDone(off, 2, p) || mDone(off - startB, 1, p)) ? 3'b100 : 3'b000;
      eFreq = mFreq(off, 700, 2, p) | mFreq(off - startB, 800, 1, p);
      eBusy = mBusy(off, 2, p, 0) | mBusy(off - startB, 1, p, 0);
      checks++;
      if ({ackB, doneB, frequencyB, busyB} !== {eAck, eDone, eFreq, eBusy}) begin
        failures++;
        $display("[TB] FAIL back_to_back off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", off, ackB, doneB, frequencyB, busyB, eAck, eDone, eFreq, eBusy);
      end
      if (eBusy) begin
        checks++;
        if (ownerB !== 2'd2) begin
          failures++;
          $display("[TB] FAIL back_to_back_owner off=%0d got %0d exp 2", off, ownerB);
        end
      end
    end
  endtask

  task automatic test_random();
    int p, last, w, f, d;
    int fArr[3];
    int dArr[3];
    logic [2:0] mask, oh, eAck, eDone;
    logic [9:0] eFreq;
    logic eBusy;
    for (int t = 0; t < 10; t++) begin
      mask = 3'($urandom_range(1, 7));
      p = $urandom_range(1, 4);
      for (int i = 0; i < 3; i++) begin
        fArr[i] = $urandom_range(0, 1023);
        dArr[i] = $urandom_range(0, 4);
      end
      w = -1;
      for (int i = 0; i < 3; i++) if (mask[i] && w < 0) w = i;
      f = fArr[w]; d = dArr[w];
      oh = 3'(1 << w);
      last = (d == 0) ? 1 : (d + GAP) * p + 1;
      for (int off = 0; off <= last; off++) begin
        @(negedge clk);
        if (off == 0) begin
          clk_counter = 16'(p - 1);
          for (int i = 0; i < 3; i++) set_field(i, fArr[i], dArr[i]);
          req = mask;
        end else begin
          req = 3'b000;
        end
        #2;
        eAck  = (off == 0) ? oh : 3'b000;
        eDone = mDone(off, d, p) ? oh : 3'b000;
        eFreq = mFreq(off, f, d, p);
        eBusy = mBusy(off, d, p, GAP);
        checks++;
        if ({ack, done, frequency, busy} !== {eAck, eDone, eFreq, eBusy}) begin
          failures++;
          $display("[TB] FAIL random t=%0d off=%0d got ack=%b done=%b freq=%0d busy=%b exp ack=%b done=%b freq=%0d busy=%b", t, off, ack, done, frequency, busy, eAck, eDone, eFreq, eBusy);
        end
        if (eBusy) begin
          checks++;
          if (owner !== 2'(w)) begin
            failures++;
            $display("[TB] FAIL random_owner t=%0d off=%0d got %0d exp %0d", t, off, owner, w);
          end
        end
      end
    end
  endtask

  initial begin
    req_freq = '0; req_dur = '0; reqFreqB = '0; reqDurB = '0;
    test_reset();
    test_single_tone();
    test_priority();
    test_zero_dur();
    test_flush();
    test_withdrawn();
    test_reset_mid_gap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
